// File: rtl/qmem_sram16_bridge.sv
// Bridges one 32-bit qmem request onto a 16-bit req/ack memory bus, big-endian halfword order.
// Define QMEM_SRAM16_BRIDGE_TIMEOUT_EN to add the memory-ack timeout and the qs_err path.
`timescale 1ns/1ps
module qmem_sram16_bridge #(
  parameter int QAW       = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           qs_cs,
  input  logic           qs_we,
  input  logic [3:0]     qs_sel,
  input  logic [QAW-1:0] qs_adr,
  input  logic [31:0]    qs_dat_w,
  output logic [31:0]    qs_dat_r,
  output logic           qs_ack,
  output logic           qs_err,
  output logic           mem_req,
  output logic           mem_we,
  output logic [1:0]     mem_sel,
  output logic [QAW-1:0] mem_adr,
  output logic [15:0]    mem_dat_w,
  input  logic [15:0]    mem_dat_r,
  input  logic           mem_ack
);

`ifdef QMEM_SRAM16_BRIDGE_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_HW0, S_HW1, S_ACK, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HW0, S_HW1, S_ACK} state_t;
`endif

  state_t         r_state;
  state_t         w_next;
  logic           r_we;
  logic [3:0]     r_sel;
  logic [QAW-1:2] r_adr;
  logic [31:0]    r_dat_w;
  logic [31:0]    r_dat_r;
  logic           r_mem_req;
  logic           w_hw;
  logic           w_enter_hw;
  logic           w_unused;

  // Address low bits are byte lanes inside the word; the bridge never looks at them.
  assign w_unused = ^{qs_adr[1:0], 32'(TO_CYCLES)};

`ifdef QMEM_SRAM16_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] LP_TO_CYCLES = 16'(TO_CYCLES);
  logic [15:0] r_cnt;
  logic        w_timeout;

  assign w_timeout = (r_cnt == LP_TO_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (w_enter_hw) begin
      r_cnt <= 16'd0;
    end else if (r_mem_req && !mem_ack) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`endif

  assign w_enter_hw = (w_next != r_state) && (w_next == S_HW0 || w_next == S_HW1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next    = r_state;
    qs_ack    = 1'b0;
    qs_err    = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 2'b00;
    mem_dat_w = 16'h0000;
    w_hw      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (qs_cs) begin
          if (qs_sel[3:2] != 2'b00)      w_next = S_HW0;
          else if (qs_sel[1:0] != 2'b00) w_next = S_HW1;
          else                           w_next = S_ACK;
        end
      end
      S_HW0: begin
        mem_we    = r_we;
        mem_sel   = r_sel[3:2];
        mem_dat_w = r_dat_w[31:16];
        if (mem_ack) w_next = (r_sel[1:0] != 2'b00) ? S_HW1 : S_ACK;
`ifdef QMEM_SRAM16_BRIDGE_TIMEOUT_EN
        else if (w_timeout) w_next = S_ERR;
`endif
      end
      S_HW1: begin
        mem_we    = r_we;
        mem_sel   = r_sel[1:0];
        mem_dat_w = r_dat_w[15:0];
        w_hw      = 1'b1;
        if (mem_ack) w_next = S_ACK;
`ifdef QMEM_SRAM16_BRIDGE_TIMEOUT_EN
        else if (w_timeout) w_next = S_ERR;
`endif
      end
      S_ACK: begin
        qs_ack = 1'b1;
        w_next = S_IDLE;
      end
`ifdef QMEM_SRAM16_BRIDGE_TIMEOUT_EN
      S_ERR: begin
        qs_err = 1'b1;
        w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_req  = r_mem_req;
  assign mem_adr  = {r_adr, w_hw, 1'b0};
  assign qs_dat_r = r_dat_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= 4'h0;
      r_adr     <= '0;
      r_dat_w   <= 32'h0;
      r_dat_r   <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_state   <= w_next;
      r_mem_req <= (w_next == S_HW0) || (w_next == S_HW1);
      if (r_state == S_IDLE && qs_cs) begin
        r_we    <= qs_we;
        r_sel   <= qs_sel;
        r_adr   <= qs_adr[QAW-1:2];
        r_dat_w <= qs_dat_w;
      end
      // Halves not accessed by this read keep whatever an earlier read left there.
      if (mem_ack && !r_we) begin
        if (r_state == S_HW0) r_dat_r[31:16] <= mem_dat_r;
        if (r_state == S_HW1) r_dat_r[15:0]  <= mem_dat_r;
      end
    end
  end

endmodule

// File: tb/tb_qmem_sram16_bridge.sv
// Self-checking bench for qmem_sram16_bridge: directed plan steps plus randomized requests
// against a byte-addressed reference memory and a word-level read-data model.
`timescale 1ns/1ps
module tb_qmem_sram16_bridge;
  localparam int QAW       = 32;
  localparam int TO_CYCLES = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           qs_cs;
  logic           qs_we;
  logic [3:0]     qs_sel;
  logic [QAW-1:0] qs_adr;
  logic [31:0]    qs_dat_w;
  logic [31:0]    qs_dat_r;
  logic           qs_ack;
  logic           qs_err;
  logic           mem_req;
  logic           mem_we;
  logic [1:0]     mem_sel;
  logic [QAW-1:0] mem_adr;
  logic [15:0]    mem_dat_w;
  logic [15:0]    mem_dat_r = 16'h0;
  logic           mem_ack   = 1'b0;

  qmem_sram16_bridge #(.QAW(QAW), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .qs_cs(qs_cs), .qs_we(qs_we), .qs_sel(qs_sel), .qs_adr(qs_adr), .qs_dat_w(qs_dat_w),
    .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_adr(mem_adr),
    .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [31:0] adr;
    logic [15:0] dat;
  } xfer_t;

  xfer_t       xfer_q[$];
  xfer_t       rec;
  logic [15:0] sram [256];
  logic [7:0]  model_mem [512];
  logic [31:0] exp_dat_r = 32'h0;
  int          cfg_wait = 0;
  bit          cfg_spurious = 1'b0;
  int          wait_cnt = 0;
  int          resp_idx;
  int          checks = 0;
  int          failures = 0;

  int lat, req_cyc, err_cyc, ack_cyc, hw1_cyc, err_lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Narrow memory slave: acks after cfg_wait wait cycles, logs every completed transfer.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= cfg_wait) begin
        resp_idx  = int'(mem_adr[8:1]);
        mem_ack   = 1'b1;
        mem_dat_r = sram[resp_idx];
        if (mem_we) begin
          if (mem_sel[1]) sram[resp_idx][15:8] = mem_dat_w[15:8];
          if (mem_sel[0]) sram[resp_idx][7:0]  = mem_dat_w[7:0];
        end
        rec.we  = mem_we;
        rec.sel = mem_sel;
        rec.adr = mem_adr;
        rec.dat = mem_dat_w;
        xfer_q.push_back(rec);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (cfg_spurious && $urandom_range(0, 1) == 1) begin
        mem_ack   = 1'b1;
        mem_dat_r = 16'($urandom);
      end
    end
  end

  task automatic set_hw(input int idx, input logic [15:0] v);
    sram[idx]             = v;
    model_mem[2*idx]      = v[15:8];
    model_mem[2*idx + 1]  = v[7:0];
  endtask

  // Issue one qmem request from a negedge, hold qs_cs until ack, scramble qs_* meanwhile.
  task automatic do_req(input string tag, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat, input int waits);
    xfer_t       exp_q[$];
    xfer_t       e;
    int          nh;
    int          idx;
    int          t_lat;
    int          t_req;
    int          t_err;
    logic [31:0] base;
    logic [1:0]  hs;
    base = {adr[31:2], 2'b00};
    nh   = 0;
    for (int h = 0; h < 2; h++) begin
      hs = (h == 0) ? sel[3:2] : sel[1:0];
      if (hs != 2'b00) begin
        e.we  = we;
        e.sel = hs;
        e.adr = base + 32'(2 * h);
        e.dat = (h == 0) ? dat[31:16] : dat[15:0];
        exp_q.push_back(e);
        nh++;
        if (!we) begin
          idx = int'(base[8:0]) + 2 * h;
          if (h == 0) exp_dat_r[31:16] = {model_mem[idx], model_mem[idx + 1]};
          else        exp_dat_r[15:0]  = {model_mem[idx], model_mem[idx + 1]};
        end
      end
    end
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (sel[3 - i]) model_mem[int'(base[8:0]) + i] = dat[31 - 8*i -: 8];
    end

    cfg_wait = waits;
    xfer_q.delete();
    qs_cs    = 1'b1;
    qs_we    = we;
    qs_sel   = sel;
    qs_adr   = adr;
    qs_dat_w = dat;
    @(posedge clk);
    t_lat = 0;
    t_req = 0;
    t_err = 0;
    do begin
      @(negedge clk);
      t_lat++;
      if (mem_req) t_req++;
      if (qs_err)  t_err++;
      qs_we    = 1'($urandom);
      qs_sel   = 4'($urandom);
      qs_adr   = $urandom;
      qs_dat_w = $urandom;
    end while (!qs_ack && t_lat < 200);
    qs_cs = 1'b0;

    check({tag, " ack_latency"}, 64'(t_lat), 64'(1 + nh * (1 + waits)));
    check({tag, " mem_req_in_ack"}, 64'(mem_req), 64'(0));
    check({tag, " qs_dat_r"}, 64'(qs_dat_r), 64'(exp_dat_r));
    check({tag, " xfer_count"}, 64'(xfer_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < xfer_q.size(); i++)
      check({tag, " xfer"}, 64'(xfer_q[i]), 64'(exp_q[i]));
    check({tag, " mem_req_cycles"}, 64'(t_req), 64'(nh * (1 + waits)));
    check({tag, " qs_err"}, 64'(t_err), 64'(0));
    @(negedge clk);
    check({tag, " ack_one_cycle"}, 64'(qs_ack), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      set_hw(i, v);
    end
    rst = 1'b1; qs_cs = 1'b0; qs_we = 1'b0; qs_sel = 4'h0; qs_adr = '0; qs_dat_w = 32'h0;
    repeat (3) @(negedge clk);
    check("reset qs_side", {27'h0, qs_dat_r, qs_ack, qs_err, 3'b000}, 64'h0);
    check("reset mem_side", {12'h0, mem_req, mem_we, mem_sel, mem_adr, mem_dat_w}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    cfg_spurious = 1'b1;

    set_hw(32'h100 >> 1, 16'h1234);
    set_hw(32'h102 >> 1, 16'hABCD);
    do_req("rd_full_imm", 1'b0, 4'hF, 32'h0000_0100, 32'h5555_AAAA, 0);
    check("rd_full_imm word", 64'(qs_dat_r), 64'h1234_ABCD);
    do_req("wr_low_half", 1'b1, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF, 0);
    do_req("sel_zero", 1'b0, 4'h0, 32'h0000_0040, 32'h0, 0);
    do_req("rd_full_wait3", 1'b0, 4'hF, 32'h0000_0104, 32'h0, 3);
    do_req("wr_hi_byte", 1'b1, 4'b1000, 32'h0000_0100, 32'h7700_0000, 1);
    do_req("rd_after_wr", 1'b0, 4'b0100, 32'h0000_0101, 32'h0, 2);

    // Reset in the middle of the second half of a read.
    cfg_wait = 3;
    xfer_q.delete();
    qs_cs = 1'b1; qs_we = 1'b0; qs_sel = 4'hF; qs_adr = 32'h0000_0040; qs_dat_w = 32'h0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(mem_req && mem_adr[1]) && lat < 50);
    check("rst hw1_reached_at", 64'(lat), 64'(5));
    rst = 1'b1;
    #1;
    check("rst mem_req_drop", 64'(mem_req), 64'(0));
    check("rst qs_ack", 64'(qs_ack), 64'(0));
    check("rst qs_dat_r", 64'(qs_dat_r), 64'(0));
    qs_cs = 1'b0;
    exp_dat_r = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    ack_cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (qs_ack || qs_err) ack_cyc++;
    end
    check("rst no_completion", 64'(ack_cyc), 64'(0));
    do_req("after_rst", 1'b0, 4'hF, 32'h0000_0040, 32'h0, 1);

`ifdef QMEM_SRAM16_BRIDGE_TIMEOUT_EN
    // Memory never answers: expect one qs_err after TO_CYCLES+1 request cycles, no second half.
    cfg_wait = 1_000_000;
    xfer_q.delete();
    qs_cs = 1'b1; qs_we = 1'b0; qs_sel = 4'hF; qs_adr = 32'h0000_0080; qs_dat_w = 32'h0;
    @(posedge clk);
    lat = 0; req_cyc = 0; err_cyc = 0; ack_cyc = 0; hw1_cyc = 0; err_lat = 0;
    repeat (20) begin
      @(negedge clk);
      lat++;
      if (mem_req) req_cyc++;
      if (mem_req && mem_adr[1]) hw1_cyc++;
      if (qs_ack) ack_cyc++;
      if (qs_err) begin
        err_cyc++;
        if (err_lat == 0) err_lat = lat;
        qs_cs = 1'b0;
      end
    end
    qs_cs = 1'b0;
    check("timeout mem_req_cycles", 64'(req_cyc), 64'(TO_CYCLES + 1));
    check("timeout err_pulses", 64'(err_cyc), 64'(1));
    check("timeout err_latency", 64'(err_lat), 64'(TO_CYCLES + 2));
    check("timeout no_ack", 64'(ack_cyc), 64'(0));
    check("timeout no_hw1", 64'(hw1_cyc), 64'(0));
    check("timeout qs_dat_r", 64'(qs_dat_r), 64'(exp_dat_r));
`endif

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_req("rand", 1'($urandom), 4'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
